// File: rtl/addsub_if.sv
// Operand/result bundle for the registered adder/subtractor.
// The master drives the operands and mode; the slave returns the result.
interface addsub_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic [WIDTH:0]   o;

    modport master (
        output a,
        output b,
        output s,
        input  o
    );

    modport slave (
        input  a,
        input  b,
        input  s,
        output o
    );
endinterface

// File: rtl/addsub.sv
// Registered WIDTH-bit adder/subtractor with a WIDTH+1 bit result.
// A single carry chain serves both modes: b is inverted and carry-in set for subtract.
module addsub #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    addsub_if.slave   bus
);
    logic [WIDTH:0] w_a_ext;
    logic [WIDTH:0] w_b_ext;
    logic [WIDTH:0] w_cin;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] r_o;

    // Subtract is a + ~b + 1 over the zero-extended operands.
    assign w_a_ext = {1'b0, bus.a};
    assign w_b_ext = {1'b0, bus.b} ^ {(WIDTH+1){~bus.s}};
    assign w_cin   = {{WIDTH{1'b0}}, ~bus.s};
    assign w_sum   = w_a_ext + w_b_ext + w_cin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o <= '0;
        end else begin
            r_o <= w_sum;
        end
    end

    assign bus.o = r_o;
endmodule

// File: tb/tb_addsub.sv
// Directed bench for addsub: literal expectations per vector plus a
// per-cycle comparison against an arithmetic model of the result register.
module tb_addsub;
    localparam int W = 8;

    logic clk;
    logic rst_n;

    addsub_if #(.WIDTH(W)) bus ();

    addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    bit armed  = 0;

    logic [W:0] m_exp;
    logic [W:0] last;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W:0] model(input int a, input int b, input bit s);
        int r;
        r = s ? (a + b) : (a - b);
        return r[W:0];
    endfunction

    task automatic check(input string name, input logic [W:0] got,
                         input logic [W:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m_exp <= '0;
        else
            m_exp <= model(int'(bus.a), int'(bus.b), bus.s);
    end

    always @(negedge clk) begin
        if (armed) check("model", bus.o, m_exp);
    end

    task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W:0] exp,
                         input string name);
        @(posedge clk);
        #2;
        bus.a = a;
        bus.b = b;
        bus.s = s;
        #2;
        check({name, "_hold"}, bus.o, last);
        @(posedge clk);
        #1;
        check(name, bus.o, exp);
        last = exp;
    endtask

    initial begin
        rst_n = 0;
        bus.a = 8'hFF;
        bus.b = 8'hFF;
        bus.s = 1'b1;
        #1;
        armed = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_hold", bus.o, 9'h000);
        end
        #2;
        rst_n = 1;
        last  = 9'h000;
        @(posedge clk);
        #1;
        check("reset_release", bus.o, 9'h1FE);
        last = 9'h1FE;

        apply(8'd159, 8'd250, 1'b1, 9'h199, "add_159_250");
        apply(8'd159, 8'd250, 1'b0, 9'h1A5, "sub_159_250");
        apply(8'd20,  8'd104, 1'b1, 9'h07C, "add_20_104");
        apply(8'd20,  8'd104, 1'b0, 9'h1AC, "sub_20_104");
        apply(8'd255, 8'd255, 1'b1, 9'h1FE, "add_max");
        apply(8'd255, 8'd0,   1'b0, 9'h0FF, "sub_255_0");
        apply(8'd0,   8'd255, 1'b0, 9'h101, "sub_0_255");
        apply(8'd0,   8'd0,   1'b1, 9'h000, "add_zero");
        apply(8'd77,  8'd77,  1'b0, 9'h000, "sub_equal");
        apply(8'd1,   8'd2,   1'b0, 9'h1FF, "sub_minus1");
        apply(8'd128, 8'd128, 1'b1, 9'h100, "add_carry");

        apply(8'd159, 8'd250, 1'b1, 9'h199, "pre_async");
        #2;
        rst_n = 0;
        #1;
        check("async_drop", bus.o, 9'h000);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("async_hold", bus.o, 9'h000);
        end
        #2;
        rst_n = 1;
        @(posedge clk);
        #1;
        check("async_release", bus.o, 9'h199);
        last = 9'h199;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            bus.a = 8'($urandom_range(0, 255));
            bus.b = 8'($urandom_range(0, 255));
            bus.s = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        armed = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
